// File: rtl/coco_ram_arbiter_if.sv
// Request, acknowledge and RAM-side signals of the CoCo main RAM arbiter.
// master: the arbiter's view; slave: the requesters and the RAM macro.
interface coco_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              vdg_req;
    logic [ADDR_W-1:0] vdg_addr;
    logic              vdg_ack;
    logic [7:0]        vdg_data;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;

    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic [7:0]        ldr_wdata;
    logic              ldr_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_q;

    modport master (
        input  vdg_req, vdg_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               ldr_req, ldr_addr, ldr_wdata, mem_q,
        output vdg_ack, vdg_data, cpu_ack, cpu_rdata, ldr_ack,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output vdg_req, vdg_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               ldr_req, ldr_addr, ldr_wdata, mem_q,
        input  vdg_ack, vdg_data, cpu_ack, cpu_rdata, ldr_ack,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/coco_ram_arbiter.sv
// Single-port main RAM arbiter: VDG > CPU > loader, loader promoted after STARVE_LIMIT CPU grants.
// Optional per-requester grant counters on dbg_grants when RAM_ARB_STATS_EN is defined.
module coco_ram_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_ena,
    coco_ram_arbiter_if.master  bus,
    output logic [23:0]         dbg_grants
);
    typedef enum logic [1:0] {IDLE, ACCESS, DATA} state_t;
    typedef enum logic [1:0] {OWN_VDG, OWN_CPU, OWN_LDR} owner_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t     state, state_nx;
    owner_t     owner, grant_owner;
    logic       grant;
    logic       acc_we;
    logic       data_done;
    logic [7:0] starve_cnt;

    always_comb begin
        state_nx    = state;
        grant       = 1'b0;
        grant_owner = OWN_VDG;
        case (state)
            IDLE: begin
                if (clk_ena) begin
                    if (bus.vdg_req) begin
                        grant       = 1'b1;
                        grant_owner = OWN_VDG;
                    end else if (bus.ldr_req && starve_cnt == STARVE_MAX) begin
                        grant       = 1'b1;
                        grant_owner = OWN_LDR;
                    end else if (bus.cpu_req) begin
                        grant       = 1'b1;
                        grant_owner = OWN_CPU;
                    end else if (bus.ldr_req) begin
                        grant       = 1'b1;
                        grant_owner = OWN_LDR;
                    end
                    if (grant) state_nx = ACCESS;
                end
            end
            ACCESS:  if (clk_ena) state_nx = DATA;
            DATA:    if (clk_ena) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= OWN_VDG;
            acc_we        <= 1'b0;
            data_done     <= 1'b0;
            starve_cnt    <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.vdg_ack   <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.ldr_ack   <= 1'b0;
            bus.vdg_data  <= '0;
            bus.cpu_rdata <= '0;
        end else begin
            state       <= state_nx;
            bus.mem_en  <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.vdg_ack <= 1'b0;
            bus.cpu_ack <= 1'b0;
            bus.ldr_ack <= 1'b0;

            // mem_en/mem_we are raised by the grant edge so they cover exactly the first ACCESS clk
            if (grant) begin
                owner      <= grant_owner;
                data_done  <= 1'b0;
                bus.mem_en <= 1'b1;
                case (grant_owner)
                    OWN_VDG: begin
                        bus.mem_addr <= bus.vdg_addr;
                        bus.mem_we   <= 1'b0;
                        acc_we       <= 1'b0;
                    end
                    OWN_CPU: begin
                        bus.mem_addr  <= bus.cpu_addr;
                        bus.mem_wdata <= bus.cpu_wdata;
                        bus.mem_we    <= bus.cpu_we;
                        acc_we        <= bus.cpu_we;
                    end
                    default: begin
                        bus.mem_addr  <= bus.ldr_addr;
                        bus.mem_wdata <= bus.ldr_wdata;
                        bus.mem_we    <= 1'b1;
                        acc_we        <= 1'b1;
                    end
                endcase
            end

            // First clk in DATA: mem_q is valid here even with a free-running clk_ena
            if (state == DATA && !data_done) begin
                data_done <= 1'b1;
                case (owner)
                    OWN_VDG: begin
                        bus.vdg_ack  <= 1'b1;
                        bus.vdg_data <= bus.mem_q;
                    end
                    OWN_CPU: begin
                        bus.cpu_ack <= 1'b1;
                        if (!acc_we) bus.cpu_rdata <= bus.mem_q;
                    end
                    default: bus.ldr_ack <= 1'b1;
                endcase
            end

            if (!bus.ldr_req)
                starve_cnt <= '0;
            else if (grant && grant_owner == OWN_LDR)
                starve_cnt <= '0;
            else if (grant && grant_owner == OWN_CPU && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [7:0] vdg_cnt, cpu_cnt, ldr_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vdg_cnt <= '0;
            cpu_cnt <= '0;
            ldr_cnt <= '0;
        end else if (grant) begin
            case (grant_owner)
                OWN_VDG: if (vdg_cnt != '1) vdg_cnt <= vdg_cnt + 8'd1;
                OWN_CPU: if (cpu_cnt != '1) cpu_cnt <= cpu_cnt + 8'd1;
                default: if (ldr_cnt != '1) ldr_cnt <= ldr_cnt + 8'd1;
            endcase
        end
    end

    assign dbg_grants = {vdg_cnt, cpu_cnt, ldr_cnt};
`else
    assign dbg_grants = '0;
`endif
endmodule

// File: tb/tb_coco_ram_arbiter.sv
// Randomized self-checking bench for coco_ram_arbiter against a behavioural RAM/priority model.
`timescale 1ns/1ps
module tb_coco_ram_arbiter;
    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int          TIMEOUT      = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_ena = 1'b0;
    logic [23:0] dbg_grants;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned ena_div   = 1;
    int unsigned ena_phase = 0;

    coco_ram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    coco_ram_arbiter #(
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_ena   (clk_ena),
        .bus       (bus),
        .dbg_grants(dbg_grants)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ena_phase = (ena_phase + 1) % ena_div;
        clk_ena   = (ena_phase == 0);
    end

    // RAM macro model: registered read, q held while not enabled
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_q <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: strobe widths, write log, ack order
    logic              prev_en = 1'b0;
    logic              prev_we = 1'b0;
    int unsigned       we_count = 0;
    logic [ADDR_W-1:0] last_we_addr = '0;
    int unsigned       cpu_ack_cnt = 0;
    int                ack_log[$];

    always @(negedge clk) begin
        if (bus.mem_en) check("mem_en_one_clk", {31'd0, prev_en}, 32'd0);
        if (bus.mem_we) begin
            check("mem_we_one_clk", {31'd0, prev_we}, 32'd0);
            check("mem_we_with_en", {31'd0, bus.mem_en}, 32'd1);
            we_count++;
            last_we_addr = bus.mem_addr;
        end
        prev_en = bus.mem_en;
        prev_we = bus.mem_we;
        if (bus.vdg_ack) ack_log.push_back(0);
        if (bus.cpu_ack) begin
            ack_log.push_back(1);
            cpu_ack_cnt++;
        end
        if (bus.ldr_ack) ack_log.push_back(2);
    end

    task automatic vdg_xfer(input logic [15:0] addr, output logic [7:0] rd);
        bit seen = 0;
        bus.vdg_addr = addr;
        bus.vdg_req  = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.vdg_ack) begin seen = 1; break; end
        end
        if (!seen) check("vdg_ack_timeout", 32'd0, 32'd1);
        bus.vdg_req = 1'b0;
        rd = bus.vdg_data;
    endtask

    task automatic cpu_xfer(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd);
        bit seen = 0;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        bus.cpu_req   = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin seen = 1; break; end
        end
        if (!seen) check("cpu_ack_timeout", 32'd0, 32'd1);
        bus.cpu_req = 1'b0;
        rd = bus.cpu_rdata;
    endtask

    task automatic ldr_xfer(input logic [15:0] addr, input logic [7:0] wd);
        bit seen = 0;
        bus.ldr_addr  = addr;
        bus.ldr_wdata = wd;
        bus.ldr_req   = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.ldr_ack) begin seen = 1; break; end
        end
        if (!seen) check("ldr_ack_timeout", 32'd0, 32'd1);
        bus.ldr_req = 1'b0;
    endtask

    task automatic wait_ldr_ack(output bit seen);
        seen = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.ldr_ack) begin seen = 1; break; end
        end
    endtask

    // CPU held high against two back-to-back loader writes: STARVE_LIMIT CPU acks before each loader ack
    task automatic starve_run(input string tag, input logic [7:0] seed);
        bit seen;
        int seg = 0;
        int cnt[2] = '{0, 0};
        int vdg_seen = 0;
        ack_log.delete();
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0400;
        bus.ldr_addr  = 16'h0500;
        bus.ldr_wdata = seed;
        bus.cpu_req   = 1'b1;
        bus.ldr_req   = 1'b1;
        wait_ldr_ack(seen);
        check({tag, "_ldr_ack1"}, {31'd0, seen}, 32'd1);
        bus.ldr_addr  = 16'h0501;
        bus.ldr_wdata = seed + 8'd1;
        wait_ldr_ack(seen);
        check({tag, "_ldr_ack2"}, {31'd0, seen}, 32'd1);
        bus.ldr_req = 1'b0;
        bus.cpu_req = 1'b0;
        repeat (10) @(negedge clk);
        foreach (ack_log[i]) begin
            if (ack_log[i] == 2) seg++;
            else if (ack_log[i] == 1 && seg < 2) cnt[seg]++;
            else if (ack_log[i] == 0) vdg_seen++;
        end
        check({tag, "_cpu_before_ldr1"}, cnt[0], STARVE_LIMIT);
        check({tag, "_cpu_before_ldr2"}, cnt[1], STARVE_LIMIT);
        check({tag, "_ldr_acks"}, seg, 2);
        check({tag, "_no_vdg"}, vdg_seen, 0);
        check({tag, "_ldr_data0"}, {24'd0, ram[16'h0500]}, {24'd0, seed});
        check({tag, "_ldr_data1"}, {24'd0, ram[16'h0501]}, {24'd0, seed + 8'd1});
    endtask

    logic [7:0]  rd, vd;
    int unsigned we0, ack0;
    logic [7:0]  shadow [0:15];
    int          exp_order[$];
    logic [2:0]  mask;
    logic [3:0]  va, ca, la;
    logic        cwe;
    logic [7:0]  cw, lw, exp_vd, exp_rd;

    initial begin
        bus.vdg_req = 1'b0; bus.vdg_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'hA5;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_vdg_ack",   {31'd0, bus.vdg_ack}, 32'd0);
        check("rst_cpu_ack",   {31'd0, bus.cpu_ack}, 32'd0);
        check("rst_ldr_ack",   {31'd0, bus.ldr_ack}, 32'd0);
        check("rst_mem_en",    {31'd0, bus.mem_en}, 32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr",  {16'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        check("rst_vdg_data",  {24'd0, bus.vdg_data}, 32'd0);
        check("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        check("rst_dbg",       {8'd0, dbg_grants}, 32'd0);

        // Reset in the middle of ACCESS aborts without an ack
        reset = 1'b1;
        @(negedge clk);
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0777; bus.cpu_wdata = 8'hEE; bus.cpu_req = 1'b1;
        @(negedge clk);
        check("abort_granted_mem_en", {31'd0, bus.mem_en}, 32'd1);
        ack0  = cpu_ack_cnt;
        reset = 1'b0;
        @(negedge clk);
        check("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
        repeat (3) @(negedge clk);
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_cpu_ack", cpu_ack_cnt - ack0, 32'd0);

        // CPU write then read
        we0 = we_count;
        cpu_xfer(1'b1, 16'h0400, 8'h5A, rd);
        check("wr_pulses", we_count - we0, 32'd1);
        check("wr_addr", {16'd0, last_we_addr}, 32'h0400);
        cpu_xfer(1'b0, 16'h0400, 8'h00, rd);
        check("rd_data", {24'd0, rd}, 32'h5A);
        check("rd_no_we", we_count - we0, 32'd1);

        // VDG and CPU rising together
        ram[16'h1234] = 8'hC3;
        repeat (2) @(negedge clk);
        ack_log.delete();
        fork
            vdg_xfer(16'h1234, vd);
            cpu_xfer(1'b0, 16'h0400, 8'h00, rd);
        join
        repeat (2) @(negedge clk);
        check("cont_acks", ack_log.size(), 32'd2);
        if (ack_log.size() == 2) begin
            check("cont_first_vdg", ack_log[0], 32'd0);
            check("cont_second_cpu", ack_log[1], 32'd1);
        end
        check("cont_vdg_data", {24'd0, vd}, 32'hC3);
        check("cont_cpu_data", {24'd0, rd}, 32'h5A);

        // Loader starvation
        starve_run("starve_a", 8'h71);
        starve_run("starve_b", 8'h39);

        // Randomized rounds at three clk_ena rates: all requesters rise together each round
        for (int i = 0; i < 16; i++) begin
            shadow[i] = 8'($urandom);
            ram[16'h0600 + 16'(i)] = shadow[i];
        end
        for (int div = 1; div <= 3; div++) begin
            ena_div = div;
            repeat (4) @(negedge clk);
            for (int r = 0; r < 20; r++) begin
                mask = 3'($urandom_range(1, 7));
                va = 4'($urandom); ca = 4'($urandom); la = 4'($urandom);
                cwe = 1'($urandom); cw = 8'($urandom); lw = 8'($urandom);
                exp_order.delete();
                if (mask[0]) exp_order.push_back(0);
                if (mask[1]) exp_order.push_back(1);
                if (mask[2]) exp_order.push_back(2);
                exp_vd = shadow[va];
                exp_rd = shadow[ca];
                if (mask[1] && cwe) shadow[ca] = cw;
                if (mask[2]) shadow[la] = lw;
                ack_log.delete();
                fork
                    if (mask[0]) vdg_xfer(16'h0600 + 16'(va), vd);
                    if (mask[1]) cpu_xfer(cwe, 16'h0600 + 16'(ca), cw, rd);
                    if (mask[2]) ldr_xfer(16'h0600 + 16'(la), lw);
                join
                repeat (2) @(negedge clk);
                check("rnd_ack_count", ack_log.size(), exp_order.size());
                if (ack_log.size() == exp_order.size())
                    foreach (exp_order[k]) check("rnd_ack_order", ack_log[k], exp_order[k]);
                if (mask[0]) check("rnd_vdg_data", {24'd0, vd}, {24'd0, exp_vd});
                if (mask[1] && !cwe) check("rnd_cpu_rdata", {24'd0, rd}, {24'd0, exp_rd});
            end
        end
        for (int i = 0; i < 16; i++)
            check("rnd_ram_final", {24'd0, ram[16'h0600 + 16'(i)]}, {24'd0, shadow[i]});

        // 300 CPU grants for the statistics counters
        ena_div = 1;
        repeat (4) @(negedge clk);
        ack0 = cpu_ack_cnt;
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0400; bus.cpu_req = 1'b1;
        for (int i = 0; i < 2000 && (cpu_ack_cnt - ack0) < 300; i++) begin
            @(negedge clk);
            #1;
        end
        bus.cpu_req = 1'b0;
        repeat (10) @(negedge clk);
        check("stats_cpu_grants_reached", {31'd0, (cpu_ack_cnt - ack0) >= 300}, 32'd1);
`ifdef RAM_ARB_STATS_EN
        check("stats_cpu_cnt_sat", {24'd0, dbg_grants[15:8]}, 32'hFF);
`else
        check("stats_dbg_zero", {8'd0, dbg_grants}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
